// File: rtl/int_to_fp13_converter_if.sv
// Handshake and result bundle between an integer source and int_to_fp13_converter.
// The master requests conversions; the slave (the converter) returns results.
interface int_to_fp13_converter_if;
  logic        start;
  logic [15:0] din;
  logic        ready;
  logic        done_tick;
  logic [12:0] fp_out;
  logic        ovf;

  modport master (
    output start, din,
    input  ready, done_tick, fp_out, ovf
  );

  modport slave (
    input  start, din,
    output ready, done_tick, fp_out, ovf
  );
endinterface

// File: rtl/int_to_fp13_converter.sv
// Serial 16-bit int to 13-bit float {sign, exp[3:0], mag[7:0]}, normalising one bit per clock.
// Define FP13_ROUND_EN for round-to-nearest (ties away from zero); the default truncates.
module int_to_fp13_converter (
  input  logic                          clk,
  input  logic                          reset,
  int_to_fp13_converter_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [15:0] m_q, m_d;
  logic [4:0]  e_q, e_d;
  logic [12:0] fp_q, fp_d;
  logic        ovf_q, ovf_d;

  logic [15:0] abs_din;
  logic [7:0]  mag_fin;
  logic [4:0]  e_fin;

  // -32768 has no positive counterpart; its 16-bit unsigned magnitude 0x8000 is still correct.
  assign abs_din = bus.din[15] ? (~bus.din + 16'd1) : bus.din;

`ifdef FP13_ROUND_EN
  logic [8:0] rnd_sum;

  // A carry out of the magnitude renormalises to 0x80 and bumps the exponent.
  always_comb begin
    rnd_sum = {1'b0, m_q[15:8]} + {8'd0, m_q[7]};
    if (rnd_sum[8]) begin
      mag_fin = 8'h80;
      e_fin   = e_q + 5'd1;
    end else begin
      mag_fin = rnd_sum[7:0];
      e_fin   = e_q;
    end
  end
`else
  assign mag_fin = m_q[15:8];
  assign e_fin   = e_q;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    sign_d  = sign_q;
    m_d     = m_q;
    e_d     = e_q;
    fp_d    = fp_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d  = bus.din[15];
          m_d     = abs_din;
          e_d     = 5'd16;
          state_d = NORM;
        end
      end
      NORM: begin
        if (m_q == 16'd0) begin
          fp_d    = 13'h000;
          ovf_d   = 1'b0;
          state_d = DONE;
        end else if (m_q[15]) begin
          if (e_fin == 5'd16) begin
            fp_d  = {sign_q, 4'hF, 8'hFF};
            ovf_d = 1'b1;
          end else begin
            fp_d  = {sign_q, e_fin[3:0], mag_fin};
            ovf_d = 1'b0;
          end
          state_d = DONE;
        end else begin
          m_d = {m_q[14:0], 1'b0};
          e_d = e_q - 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      m_q     <= 16'd0;
      e_q     <= 5'd0;
      fp_q    <= 13'h000;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      m_q     <= m_d;
      e_q     <= e_d;
      fp_q    <= fp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.done_tick = (state_q == DONE);
  assign bus.fp_out    = fp_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_int_to_fp13_converter.sv
// Self-checking bench for int_to_fp13_converter: directed corner cases plus random operands
// compared against an arithmetic reference model (follows FP13_ROUND_EN when defined).
module tb_int_to_fp13_converter;

  logic clk;
  logic reset;
  int_to_fp13_converter_if bus ();

  int_to_fp13_converter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value = 0.mag * 2^e with e = bit length of |din|.
  function automatic void model(input logic [15:0] d, output logic [12:0] fp,
                                output logic o, output int lat);
    int a;
    int e;
    int mag;
    a = d[15] ? (65536 - int'(d)) : int'(d);
    if (a == 0) begin
      fp = 13'h000; o = 1'b0; lat = 2;
      return;
    end
    e = 0;
    while ((1 << e) <= a) e++;
    lat = 18 - e;
`ifdef FP13_ROUND_EN
    mag = (a * 256 + (1 << (e - 1))) >> e;
    if (mag == 256) begin
      mag = 128;
      e++;
    end
`else
    mag = (a * 256) >> e;
`endif
    if (e >= 16) begin
      fp = {d[15], 4'hF, 8'hFF}; o = 1'b1;
    end else begin
      fp = {d[15], 4'(e), 8'(mag)}; o = 1'b0;
    end
  endfunction

  function automatic int fp_val(input logic [12:0] f);
    int v;
    v = int'(f[7:0]) << f[11:8];
    return f[12] ? -v : v;
  endfunction

  task automatic wait_done(inout int lat);
    while (!bus.done_tick && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done_tick) lat = -1;
  endtask

  // Runs one conversion from IDLE; lat counts the start edge as cycle 1.
  task automatic convert(input logic [15:0] d, output logic [12:0] fp,
                         output logic o, output int lat);
    @(negedge clk);
    bus.din   = d;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    wait_done(lat);
    fp = bus.fp_out;
    o  = bus.ovf;
    if (lat < 0) begin
      check("done_timeout", 32'(lat), 32'd0);
      return;
    end
    @(posedge clk); #1;
    check("ready_after_done", 32'(bus.ready), 32'd1);
    check("done_single_pulse", 32'(bus.done_tick), 32'd0);
    check("fp_held", 32'(bus.fp_out), 32'(fp));
  endtask

  logic [15:0] dir_tab [8] = '{16'h0001, 16'h0100, 16'hFFFF, 16'h0000,
                               16'h8000, 16'h7FFF, 16'h012C, 16'hFED4};

  initial begin
    logic [12:0] fp, exp_fp, r1, r2, r3;
    logic        o, exp_o;
    int          lat, exp_lat, seen;
    logic [15:0] d;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.din   = 16'h0000;
    #12;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done_tick), 32'd0);
    check("rst_fp", 32'(bus.fp_out), 32'h000);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed corners against the model
    for (int i = 0; i < 8; i++) begin
      model(dir_tab[i], exp_fp, exp_o, exp_lat);
      convert(dir_tab[i], fp, o, lat);
      check($sformatf("dir_fp_%h", dir_tab[i]), 32'(fp), 32'(exp_fp));
      check($sformatf("dir_ovf_%h", dir_tab[i]), 32'(o), 32'(exp_o));
      check($sformatf("dir_lat_%h", dir_tab[i]), 32'(lat), 32'(exp_lat));
    end

    // Hand-derived constants for a few corners
    convert(16'h0001, fp, o, lat);
    check("const_0001_fp", 32'(fp), 32'h180);
    check("const_0001_lat", 32'(lat), 32'd17);
    convert(16'h0100, fp, o, lat);
    check("const_0100_fp", 32'(fp), 32'h980);
    check("const_0100_lat", 32'(lat), 32'd9);
    convert(16'h0000, fp, o, lat);
    check("const_zero_lat", 32'(lat), 32'd2);
    convert(16'h8000, fp, o, lat);
    check("const_8000_fp", 32'(fp), 32'h1FFF);
    check("const_8000_ovf", 32'(o), 32'd1);
    convert(16'h7FFF, fp, o, lat);
    check("const_7fff_fp", 32'(fp), 32'h0FFF);
    check("const_7fff_lat", 32'(lat), 32'd3);
`ifdef FP13_ROUND_EN
    check("const_7fff_ovf", 32'(o), 32'd1);
`else
    check("const_7fff_ovf", 32'(o), 32'd0);
`endif

    // Start while busy is ignored
    @(negedge clk);
    bus.din   = 16'h0100;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    @(negedge clk);
    bus.din   = 16'h0001;
    bus.start = 1'b1;
    check("busy_ready_low", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat++;
    wait_done(lat);
    check("busy_lat", 32'(lat), 32'd9);
    check("busy_fp", 32'(bus.fp_out), 32'h980);
    repeat (3) @(posedge clk);
    #1;
    check("busy_no_second", 32'(bus.ready), 32'd1);
    check("busy_fp_kept", 32'(bus.fp_out), 32'h980);

    // Reset asserted during NORM
    @(negedge clk);
    bus.din   = 16'h0100;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_fp", 32'(bus.fp_out), 32'h000);
    check("midrst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done_tick) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    // Back-to-back operands for the comparator stage
    convert(16'd300, r1, o, lat);
    convert(-16'sd300, r2, o, lat);
    model(16'd300, exp_fp, exp_o, exp_lat);
    check("b2b_300_fp", 32'(r1), 32'(exp_fp));
    check("cmp_gt", 32'(fp_val(r1) > fp_val(r2)), 32'd1);
    check("cmp_lt", 32'(fp_val(r1) < fp_val(r2)), 32'd0);
    convert(16'd300, r3, o, lat);
    check("cmp_eq", 32'(fp_val(r3) == fp_val(r1)), 32'd1);

    // Random operands, half of them scaled down to exercise long normalisation
    for (int i = 0; i < 60; i++) begin
      d = 16'($urandom);
      if (i % 2 == 1) d = d >> $urandom_range(0, 15);
      model(d, exp_fp, exp_o, exp_lat);
      convert(d, fp, o, lat);
      check($sformatf("rnd_fp_%h", d), 32'(fp), 32'(exp_fp));
      check($sformatf("rnd_ovf_%h", d), 32'(o), 32'(exp_o));
      check($sformatf("rnd_lat_%h", d), 32'(lat), 32'(exp_lat));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
